// File: rtl/switch_input_port.sv
// Memory-mapped switch input port: captures the board switches on a debounced
// confirm-button press and holds the word with a ready flag until the CPU pops it.
module switch_input_port #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] switches,
    input  logic        confirm_bt,
    input  logic        ior,
    input  logic        switchctrl,
    input  logic [1:0]  addr_sel,
    output logic [15:0] ioread_data,
    output logic        ready
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 btn_meta_r;
    logic                 btn_sync_r;
    logic [15:0]          sw_meta_r;
    logic [15:0]          sw_sync_r;
    state_t               state_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [15:0]          data_r;
    logic                 ready_r;
    logic                 overflow_r;
    logic [7:0]           cap_count_r;
    logic                 cap_fire_s;
    logic                 rd_en_s;
    logic                 pop_s;
    logic                 stat_clr_s;
    logic [15:0]          rd_data_s;

    // Two-stage synchronizers for the asynchronous button and switches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
            sw_meta_r  <= 16'h0000;
            sw_sync_r  <= 16'h0000;
        end else begin
            btn_meta_r <= confirm_bt;
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= switches;
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Debounce FSM: a press or release must stay stable for DEBOUNCE_CYCLES.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (btn_sync_r) begin
                        state_r <= PRESS_WAIT;
                        cnt_r   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync_r) begin
                        state_r <= IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= HELD;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!btn_sync_r) begin
                        state_r <= RELEASE_WAIT;
                        cnt_r   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync_r) begin
                        state_r <= HELD;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Capture strobe is high for the single cycle in which PRESS_WAIT completes.
    always_comb begin
        cap_fire_s = 1'b0;
        if ((state_r == PRESS_WAIT) && btn_sync_r && (cnt_r == CNT_LAST)) begin
            cap_fire_s = 1'b1;
        end else begin
            cap_fire_s = 1'b0;
        end
    end

    // Bus decode: DATA pops ready, STATUS clears overflow.
    always_comb begin
        rd_en_s    = ior & switchctrl;
        pop_s      = 1'b0;
        stat_clr_s = 1'b0;
        rd_data_s  = 16'h0000;
        if (rd_en_s) begin
            case (addr_sel)
                2'b00: begin
                    rd_data_s = data_r;
                    pop_s     = 1'b1;
                end
                2'b01: begin
                    rd_data_s  = {cap_count_r, 6'b000000, overflow_r, ready_r};
                    stat_clr_s = 1'b1;
                end
                2'b10:   rd_data_s = sw_sync_r;
                default: rd_data_s = 16'h0000;
            endcase
        end else begin
            rd_data_s = 16'h0000;
        end
    end

    // Captured word, ready/overflow flags and capture counter; capture beats pop and clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_r      <= 16'h0000;
            ready_r     <= 1'b0;
            overflow_r  <= 1'b0;
            cap_count_r <= 8'h00;
        end else begin
            if (cap_fire_s) begin
                data_r      <= sw_sync_r;
                ready_r     <= 1'b1;
                cap_count_r <= cap_count_r + 8'h01;
            end else if (pop_s) begin
                ready_r <= 1'b0;
            end else begin
                ready_r <= ready_r;
            end
            if (cap_fire_s && ready_r && !pop_s) begin
                overflow_r <= 1'b1;
            end else if (stat_clr_s) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign ioread_data = rd_data_s;
    assign ready       = ready_r;

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with a queue of expected captured words.
module tb_switch_input_port;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] switches = 16'h0000;
    logic        confirm_bt = 1'b0;
    logic        ior = 1'b0;
    logic        switchctrl = 1'b0;
    logic [1:0]  addr_sel = 2'b00;
    logic [15:0] ioread_data;
    logic        ready;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] rd;
    logic [15:0] exp_d;
    int n;
    logic bounced;

    switch_input_port #(.DEBOUNCE_CYCLES(8), .CNT_WIDTH(4)) dut (
        .clock(clock), .reset(reset), .switches(switches), .confirm_bt(confirm_bt),
        .ior(ior), .switchctrl(switchctrl), .addr_sel(addr_sel),
        .ioread_data(ioread_data), .ready(ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge clock);
        ior = 1'b1; switchctrl = 1'b1; addr_sel = a;
        #1 d = ioread_data;
        @(negedge clock);
        ior = 1'b0; switchctrl = 1'b0; addr_sel = 2'b00;
    endtask

    task automatic read_data_check(input string tag);
        logic [15:0] d;
        logic [15:0] e;
        e = (exp_q.size() > 0) ? exp_q[$] : 16'h0000;
        exp_q.delete();
        do_read(2'b00, d);
        check(tag, d, e);
    endtask

    task automatic wait_ready(input int max, output int cnt);
        cnt = 0;
        while (cnt < max) begin
            @(posedge clock);
            cnt++;
            @(negedge clock);
            if (ready === 1'b1) break;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic press(input logic [15:0] v);
        @(negedge clock);
        switches = v;
        repeat (3) @(negedge clock);
        confirm_bt = 1'b1;
        exp_q.push_back(v);
        repeat (14) @(negedge clock);
        confirm_bt = 1'b0;
        repeat (14) @(negedge clock);
    endtask

    initial begin
        // Reset held with switches and button active: everything reads zero.
        switches = 16'hFFFF; confirm_bt = 1'b1; reset = 1'b0;
        repeat (4) @(negedge clock);
        ior = 1'b1; switchctrl = 1'b1;
        for (int a = 0; a < 4; a++) begin
            addr_sel = 2'(a);
            #1 check("reset_rd", ioread_data, 16'h0000);
            check("reset_ready", {15'd0, ready}, 16'h0000);
        end
        ior = 1'b0; switchctrl = 1'b0; addr_sel = 2'b00;
        @(negedge clock);
        reset = 1'b1;
        exp_q.push_back(16'hFFFF);
        wait_ready(40, n);
        check("reset_latency", 16'(n), 16'd11);
        confirm_bt = 1'b0;
        repeat (14) @(negedge clock);
        read_data_check("reset_data");

        // Clean press.
        do_reset();
        @(negedge clock);
        switches = 16'hA5C3;
        repeat (3) @(negedge clock);
        confirm_bt = 1'b1;
        exp_q.push_back(16'hA5C3);
        wait_ready(40, n);
        check("press_latency", 16'(n), 16'd11);
        repeat (8) @(negedge clock);
        confirm_bt = 1'b0;
        read_data_check("press_data");
        check("press_pop", {15'd0, ready}, 16'h0000);
        do_read(2'b01, rd);
        check("press_status", rd, 16'h0100);
        repeat (14) @(negedge clock);

        // Bouncing button: no capture while toggling, exactly one afterwards.
        do_reset();
        @(negedge clock);
        switches = 16'h3C3C;
        repeat (3) @(negedge clock);
        bounced = 1'b0;
        for (int t = 0; t < 10; t++) begin
            confirm_bt = ~confirm_bt;
            repeat (3) begin
                @(negedge clock);
                if (ready === 1'b1) bounced = 1'b1;
            end
        end
        check("bounce_quiet", {15'd0, bounced}, 16'h0000);
        confirm_bt = 1'b1;
        exp_q.push_back(16'h3C3C);
        wait_ready(40, n);
        check("bounce_ready", {15'd0, ready}, 16'h0001);
        repeat (10) @(negedge clock);
        confirm_bt = 1'b0;
        repeat (14) @(negedge clock);
        do_read(2'b01, rd);
        check("bounce_status", rd, 16'h0101);
        read_data_check("bounce_data");

        // Overflow: two captures without a read, newest wins.
        do_reset();
        press(16'h0001);
        press(16'h0002);
        do_read(2'b01, rd);
        check("ovf_status1", rd, 16'h0203);
        do_read(2'b01, rd);
        check("ovf_status2", rd, 16'h0201);
        read_data_check("ovf_data");
        do_read(2'b01, rd);
        check("ovf_status3", rd, 16'h0200);

        // Collision: DATA pop in the same cycle as a capture.
        do_reset();
        press(16'h0F0F);
        @(negedge clock);
        switches = 16'h1234;
        repeat (3) @(negedge clock);
        confirm_bt = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("coll_ready_before", {15'd0, ready}, 16'h0001);
        exp_d = exp_q[$];
        exp_q.delete();
        ior = 1'b1; switchctrl = 1'b1; addr_sel = 2'b00;
        #1 check("coll_old_data", ioread_data, exp_d);
        exp_q.push_back(16'h1234);
        @(negedge clock);
        ior = 1'b0; switchctrl = 1'b0;
        check("coll_ready_after", {15'd0, ready}, 16'h0001);
        do_read(2'b01, rd);
        check("coll_status", rd, 16'h0201);
        read_data_check("coll_new_data");
        confirm_bt = 1'b0;
        repeat (14) @(negedge clock);

        // Counter wrap after 256 captures.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            press(16'(i));
            if (i == 254) begin
                do_read(2'b01, rd);
                check("wrap_status255", rd, 16'hFF03);
            end
        end
        do_read(2'b01, rd);
        check("wrap_status256", rd, 16'h0003);

        // LIVE read tracks switches with two cycles of latency, no side effects.
        @(negedge clock);
        ior = 1'b1; switchctrl = 1'b1; addr_sel = 2'b10;
        #1 check("live_old", ioread_data, 16'h00FF);
        switches = 16'h5A5A;
        @(negedge clock);
        #1 check("live_1cyc", ioread_data, 16'h00FF);
        @(negedge clock);
        #1 check("live_2cyc", ioread_data, 16'h5A5A);
        addr_sel = 2'b11;
        #1 check("addr11", ioread_data, 16'h0000);
        switchctrl = 1'b0; addr_sel = 2'b00;
        #1 check("unselected", ioread_data, 16'h0000);
        @(negedge clock);
        ior = 1'b0;
        check("live_ready", {15'd0, ready}, 16'h0001);
        read_data_check("wrap_data");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
